adder_tree_pipe: RTL and testbench



---
 rtl/adder_tree_pkg.sv | 21 ++
 rtl/adder_tree_pipe_if.sv | 28 ++
 rtl/adder_tree_level.sv | 63 ++++++
 rtl/adder_tree_pipe.sv | 128 ++++++++++++
 tb/tb_adder_tree_pipe.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_tree_pkg.sv
// Shared defaults and width helpers for the pipelined adder tree.
package adder_tree_pkg;

  localparam int DEF_N_IN   = 8;
  localparam int DEF_IN_W   = 8;
  localparam int DEF_ACC_XW = 8;

  // Ceiling log2; used to derive the tree depth from the operand count.
  function automatic int log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Each level grows the partial sums by exactly one bit.
  function automatic int width_at(input int in_w, input int lvl);
    return in_w + lvl;
  endfunction

endpackage

// File: rtl/adder_tree_pipe_if.sv
// Operand/result handshake bundle for adder_tree_pipe; master is the producer/consumer side.
interface adder_tree_pipe_if
  import adder_tree_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int IN_W   = DEF_IN_W,
  parameter int OUT_DW = DEF_IN_W + 3
);

  logic [N_IN*IN_W-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_last;
  logic [OUT_DW-1:0]    out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/adder_tree_level.sv
// One registered pairwise-add level: N inputs of W bits -> N/2 sums of W+1 bits, 1 cycle.
// All state holds while en=0; the caller owns backpressure through en.
module adder_tree_level
  import adder_tree_pkg::*;
#(
  parameter int N      = 8,
  parameter int W      = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               en,
  input  logic [N*W-1:0]                     in_dat,
  input  logic                               in_vld,
  input  logic                               in_last,
  output logic [(N/2)*width_at(W, 1)-1:0]    out_dat,
  output logic                               out_vld,
  output logic                               out_last
);

  localparam int NO = N / 2;
  localparam int WO = width_at(W, 1);

  logic [NO*WO-1:0] dat_d, dat_q;
  logic             vld_d, vld_q;
  logic             last_d, last_q;
  logic [WO-1:0]    a_x, b_x;

  always_comb begin
    dat_d  = dat_q;
    vld_d  = vld_q;
    last_d = last_q;
    a_x    = '0;
    b_x    = '0;
    if (en) begin
      vld_d  = in_vld;
      last_d = in_last;
      // Extend both operands by one bit so the pair sum can never overflow.
      for (int i = 0; i < NO; i++) begin
        a_x = {SIGNED & in_dat[(2*i+1)*W-1], in_dat[(2*i)*W +: W]};
        b_x = {SIGNED & in_dat[(2*i+2)*W-1], in_dat[(2*i+1)*W +: W]};
        dat_d[i*WO +: WO] = a_x + b_x;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dat_q  <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      dat_q  <= dat_d;
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end

  assign out_dat  = dat_q;
  assign out_vld  = vld_q;
  assign out_last = last_q;

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined N_IN-operand adder tree, LVLS cycles (LVLS+1 with ADDER_TREE_ACC_EN accumulator).
// A single enable stalls every level while a result waits on out_ready; in_ready mirrors it.
module adder_tree_pipe
  import adder_tree_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int IN_W   = DEF_IN_W,
  parameter int SIGNED = 0,
  parameter int ACC_XW = DEF_ACC_XW
) (
  input logic              clk,
  input logic              reset,
  adder_tree_pipe_if.slave bus
);

  localparam int LVLS  = log2(N_IN);
  localparam int OUT_W = width_at(IN_W, LVLS);
`ifdef ADDER_TREE_ACC_EN
  localparam int OUT_DW = OUT_W + ACC_XW;
`else
  localparam int OUT_DW = OUT_W;
`endif

  if (N_IN < 2 || (N_IN & (N_IN - 1)) != 0) begin : g_bad_n_in
    $error("adder_tree_pipe: N_IN must be a power of two >= 2");
  end
  if (ACC_XW < 0) begin : g_bad_acc_xw
    $error("adder_tree_pipe: ACC_XW must be non-negative");
  end

  logic             en;
  logic             out_vld;
  logic             tree_vld;
  logic             tree_last;
  logic [OUT_W-1:0] tree_sum;

  // The only out_ready -> in_ready path: the whole pipe moves or nothing does.
  assign en           = !out_vld || bus.out_ready;
  assign bus.in_ready = en;

  for (genvar l = 0; l < LVLS; l++) begin : g_lvl
    localparam int NI = N_IN >> l;
    localparam int WI = width_at(IN_W, l);

    logic [NI*WI-1:0]                in_dat;
    logic                            in_vld;
    logic                            in_last;
    logic [(NI/2)*(WI+1)-1:0]        out_dat;
    logic                            out_vld;
    logic                            out_last;

    if (l == 0) begin : g_head
      assign in_dat  = bus.in_data;
      assign in_vld  = bus.in_valid;
      assign in_last = bus.in_last;
    end else begin : g_body
      assign in_dat  = g_lvl[l-1].out_dat;
      assign in_vld  = g_lvl[l-1].out_vld;
      assign in_last = g_lvl[l-1].out_last;
    end

    adder_tree_level #(
      .N      (NI),
      .W      (WI),
      .SIGNED (SIGNED != 0)
    ) u_level (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .in_dat   (in_dat),
      .in_vld   (in_vld),
      .in_last  (in_last),
      .out_dat  (out_dat),
      .out_vld  (out_vld),
      .out_last (out_last)
    );
  end

  assign tree_sum  = g_lvl[LVLS-1].out_dat;
  assign tree_vld  = g_lvl[LVLS-1].out_vld;
  assign tree_last = g_lvl[LVLS-1].out_last;

`ifdef ADDER_TREE_ACC_EN
  logic [OUT_DW-1:0] acc_d, acc_q;
  logic [OUT_DW-1:0] sum_x;
  logic              first_d, first_q;
  logic              vld_d, vld_q;

  always_comb begin
    acc_d   = acc_q;
    first_d = first_q;
    vld_d   = vld_q;
    if (SIGNED != 0) sum_x = OUT_DW'($signed(tree_sum));
    else             sum_x = OUT_DW'(tree_sum);
    if (en) begin
      // Only a group's last beat raises out_valid, so partial beats never wait on out_ready.
      vld_d = tree_vld && tree_last;
      if (tree_vld) begin
        acc_d   = (first_q ? '0 : acc_q) + sum_x;
        first_d = tree_last;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      first_q <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      first_q <= first_d;
      vld_q   <= vld_d;
    end
  end

  assign out_vld      = vld_q;
  assign bus.out_data = acc_q;
`else
  logic unused_last;
  assign unused_last  = tree_last;
  assign out_vld      = tree_vld;
  assign bus.out_data = tree_sum;
`endif

  assign bus.out_valid = out_vld;

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Bench for adder_tree_pipe: directed cases plus randomized traffic against an arithmetic model.
module tb_adder_tree_pipe;

  localparam int N_IN   = 8;
  localparam int IN_W   = 8;
  localparam int ACC_XW = 8;
  localparam int LVLS   = $clog2(N_IN);
  localparam int OUT_W  = IN_W + LVLS;
`ifdef ADDER_TREE_ACC_EN
  localparam int OW  = OUT_W + ACC_XW;
  localparam int LAT = LVLS + 1;
  localparam bit ACC = 1'b1;
`else
  localparam int OW  = OUT_W;
  localparam int LAT = LVLS;
  localparam bit ACC = 1'b0;
`endif
  localparam logic [63:0] MASK = (64'd1 << OW) - 64'd1;

  typedef logic [N_IN*IN_W-1:0] vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  adder_tree_pipe_if #(.N_IN(N_IN), .IN_W(IN_W), .OUT_DW(OW)) ub ();
  adder_tree_pipe_if #(.N_IN(N_IN), .IN_W(IN_W), .OUT_DW(OW)) sbus ();

  adder_tree_pipe #(.N_IN(N_IN), .IN_W(IN_W), .SIGNED(0), .ACC_XW(ACC_XW)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ub)
  );

  adder_tree_pipe #(.N_IN(N_IN), .IN_W(IN_W), .SIGNED(1), .ACC_XW(ACC_XW)) u_dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (sbus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;
  int n_spur = 0;
  int n_break = 0;
  int cyc_n = 0;
  int last_out_cyc = -10;
  logic [63:0] exp_q[$];
  logic [63:0] acc_total = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] usum(input vec_t v);
    logic [63:0] s;
    s = '0;
    for (int k = 0; k < N_IN; k++) s += 64'(v[k*IN_W +: IN_W]);
    return s;
  endfunction

  function automatic logic [63:0] ssum(input vec_t v);
    longint s;
    s = 0;
    for (int k = 0; k < N_IN; k++) s += longint'($signed(v[k*IN_W +: IN_W]));
    return 64'(s) & MASK;
  endfunction

  function automatic vec_t fill(input logic [IN_W-1:0] val);
    vec_t v;
    for (int k = 0; k < N_IN; k++) v[k*IN_W +: IN_W] = val;
    return v;
  endfunction

  function automatic vec_t rnd_vec();
    vec_t v;
    for (int k = 0; k < N_IN; k++) v[k*IN_W +: IN_W] = IN_W'($urandom);
    return v;
  endfunction

  // Scoreboard for the unsigned instance: a group total is expected per last beat.
  task automatic monitor();
    if (ub.out_valid && ub.out_ready) begin
      if (exp_q.size() == 0) n_spur++;
      else check("sb_data", 64'(ub.out_data), exp_q.pop_front());
      if (cyc_n != last_out_cyc + 1) n_break++;
      last_out_cyc = cyc_n;
      n_out++;
    end
    if (ub.in_valid && ub.in_ready) begin
      acc_total = (acc_total + usum(ub.in_data)) & MASK;
      if (!ACC || ub.in_last) begin
        exp_q.push_back(acc_total);
        acc_total = '0;
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic sgn_beat(input vec_t v, input string tag);
    sbus.in_data  = v;
    sbus.in_valid = 1'b1;
    cyc();
    sbus.in_valid = 1'b0;
    for (int c = 1; c < LAT; c++) cyc();
    check({tag, "_vld"}, 64'(sbus.out_valid), 64'd1);
    check(tag, 64'(sbus.out_data), ssum(v));
    cyc();
  endtask

  initial begin
    vec_t v;
    int   o0;
    int   b0;
    int   pat[8] = '{1, -1, 2, -2, 3, -3, 4, -4};

    reset          = 1'b1;
    ub.in_data     = '0;
    ub.in_valid    = 1'b0;
    ub.in_last     = 1'b1;
    ub.out_ready   = 1'b1;
    sbus.in_data   = '0;
    sbus.in_valid  = 1'b0;
    sbus.in_last   = 1'b1;
    sbus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_out_valid", 64'(ub.out_valid), 64'd0);
    check("rst_out_data", 64'(ub.out_data), 64'd0);
    check("rst_in_ready", 64'(ub.in_ready), 64'd1);
    check("rst_s_out_data", 64'(sbus.out_data), 64'd0);

    // Single all-ones beat: exact latency and full-scale sum.
    ub.in_data  = fill(8'hFF);
    ub.in_valid = 1'b1;
    cyc();
    ub.in_valid = 1'b0;
    for (int c = 1; c < LAT; c++) begin
      check("t1_early_vld", 64'(ub.out_valid), 64'd0);
      cyc();
    end
    check("t1_vld", 64'(ub.out_valid), 64'd1);
    check("t1_sum", 64'(ub.out_data), 64'd2040);
    cyc();
    check("t1_single", 64'(ub.out_valid), 64'd0);

    // Signed instance: most-negative operands, cancelling pairs, random vectors.
    sgn_beat(fill(8'h80), "t2_neg");
    for (int k = 0; k < N_IN; k++) v[k*IN_W +: IN_W] = IN_W'(pat[k]);
    sgn_beat(v, "t2_cancel");
    repeat (3) sgn_beat(rnd_vec(), "t2_rand");

    // Back-to-back stream, operands i+k.
    b0 = n_break;
    o0 = n_out;
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < N_IN; i++) ub.in_data[i*IN_W +: IN_W] = IN_W'(i + k);
      ub.in_valid = 1'b1;
      cyc();
    end
    ub.in_valid = 1'b0;
    repeat (LAT + 2) cyc();
    check("t3_count", 64'(n_out - o0), 64'd10);
    check("t3_gapless", 64'(n_break - b0), 64'd1);

    // Backpressure with three beats in flight.
    ub.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ub.in_data  = rnd_vec();
      ub.in_valid = 1'b1;
      cyc();
    end
    ub.in_valid = 1'b0;
    for (int w = 0; w < LAT + 2 && !ub.out_valid; w++) cyc();
    check("t4_reach_vld", 64'(ub.out_valid), 64'd1);
    ub.in_data  = rnd_vec();
    ub.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("t4_in_ready", 64'(ub.in_ready), 64'd0);
      check("t4_hold_vld", 64'(ub.out_valid), 64'd1);
      check("t4_hold_data", 64'(ub.out_data), exp_q[0]);
      cyc();
    end
    ub.in_valid  = 1'b0;
    ub.out_ready = 1'b1;
    o0 = n_out;
    repeat (LAT + 3) cyc();
    check("t4_drained", 64'(n_out - o0), 64'd3);

`ifdef ADDER_TREE_ACC_EN
    // Four all-ones beats forming one group.
    o0 = n_out;
    ub.in_data  = fill(8'h01);
    ub.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ub.in_last = (k == 3);
      cyc();
    end
    ub.in_valid = 1'b0;
    ub.in_last  = 1'b1;
    for (int c = 1; c < LAT; c++) begin
      check("t6_early_vld", 64'(ub.out_valid), 64'd0);
      cyc();
    end
    check("t6_vld", 64'(ub.out_valid), 64'd1);
    check("t6_total", 64'(ub.out_data), 64'd32);
    cyc();
    check("t6_pulse", 64'(ub.out_valid), 64'd0);
    check("t6_count", 64'(n_out - o0), 64'd1);
`endif

    // Random traffic with random backpressure.
    for (int c = 0; c < 300; c++) begin
      ub.in_valid  = ($urandom_range(3) != 0);
      ub.in_data   = rnd_vec();
      ub.out_ready = ($urandom_range(2) != 0);
      ub.in_last   = ACC ? ($urandom_range(2) == 0) : 1'b1;
      cyc();
    end
    ub.in_valid  = 1'b0;
    ub.out_ready = 1'b1;
    ub.in_last   = 1'b1;
    repeat (LAT + 4) cyc();
    check("t7_drained", 64'(exp_q.size()), 64'd0);

    // Reset with two beats in flight discards them.
    for (int k = 0; k < 2; k++) begin
      ub.in_data  = rnd_vec();
      ub.in_valid = 1'b1;
      cyc();
    end
    ub.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("t5_rst_vld", 64'(ub.out_valid), 64'd0);
    check("t5_rst_data", 64'(ub.out_data), 64'd0);
    check("t5_rst_in_ready", 64'(ub.in_ready), 64'd1);
    exp_q.delete();
    acc_total = '0;
    cyc();
    reset = 1'b0;
    o0 = n_out;
    repeat (LAT + 3) cyc();
    check("t5_no_stale", 64'(n_out - o0), 64'd0);
    ub.in_data  = rnd_vec();
    ub.in_valid = 1'b1;
    cyc();
    ub.in_valid = 1'b0;
    repeat (LAT + 2) cyc();
    check("t5_fresh", 64'(n_out - o0), 64'd1);
    check("t5_empty", 64'(exp_q.size()), 64'd0);
    check("no_spurious", 64'(n_spur), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
